// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: a fetch port and a data port share one memory bus.
// Data requests win ties unless the fetch port has been starved STARVE_LIMIT times.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        err
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BUSY_I = 3'd1;
  localparam logic [2:0] S_BUSY_D = 3'd2;
  localparam logic [2:0] S_RESP_I = 3'd3;
  localparam logic [2:0] S_RESP_D = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [2:0]        r_starve;
  logic [WAIT_W-1:0] r_wait;
  logic              r_err;
  logic [31:0]       r_if_rdata;
  logic [31:0]       r_d_rdata;
  logic              w_busy;
  logic              w_expire;

  assign w_busy   = (r_state == S_BUSY_I) || (r_state == S_BUSY_D);
  assign w_expire = w_busy && !mem_ready && (r_wait == WAIT_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (if_req && d_req)
          w_next = (r_starve == STARVE_MAX) ? S_BUSY_I : S_BUSY_D;
        else if (if_req)
          w_next = S_BUSY_I;
        else if (d_req)
          w_next = S_BUSY_D;
      end
      S_BUSY_I: if (mem_ready || w_expire) w_next = S_RESP_I;
      S_BUSY_D: if (mem_ready || w_expire) w_next = S_RESP_D;
      S_RESP_I: w_next = S_IDLE;
      S_RESP_D: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_starve   <= 3'd0;
      r_wait     <= '0;
      r_err      <= 1'b0;
      r_if_rdata <= 32'd0;
      r_d_rdata  <= 32'd0;
    end else begin
      r_state <= w_next;
      r_err   <= w_expire;
      if (r_state == S_IDLE) begin
        r_wait <= '0;
        if (w_next == S_BUSY_I)
          r_starve <= 3'd0;
        else if ((w_next == S_BUSY_D) && if_req && (r_starve != 3'd7))
          r_starve <= r_starve + 3'd1;
      end else if (w_busy) begin
        r_wait <= r_wait + WAIT_W'(1);
      end
      // Stores and timed-out accesses leave the read-data registers untouched.
      if ((r_state == S_BUSY_I) && mem_ready)
        r_if_rdata <= mem_rdata;
      if ((r_state == S_BUSY_D) && mem_ready && !d_we)
        r_d_rdata <= mem_rdata;
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    case (r_state)
      S_BUSY_I: begin
        mem_req  = 1'b1;
        mem_addr = if_addr;
      end
      S_BUSY_D: begin
        mem_req   = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end
      default: ;
    endcase
  end

  assign if_ack   = (r_state == S_RESP_I);
  assign d_ack    = (r_state == S_RESP_D);
  assign err      = r_err;
  assign if_rdata = r_if_rdata;
  assign d_rdata  = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a small memory model answers bus requests,
// expected grants and acks are queued as stimulus is driven and popped as they appear.
module tb_mem_arbiter;

  typedef struct {
    bit          port_d;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'd0;
  logic [31:0] d_wdata = 32'd0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ready = 1'b0;
  logic        err;

  int checks = 0;
  int failures = 0;

  exp_t        exp_q[$];
  logic [31:0] grant_q[$];

  bit mon_en = 0;
  bit mem_en = 1;
  int mem_wait = 0;
  bit if_hold = 0;
  bit d_hold = 0;
  bit chk_store = 0;
  int n_store = 0;
  int n_busy = 0;
  int n_d_ack = 0;

  mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h0040_0000) ? 32'h2008_0005 : (a ^ 32'h5A5A_5A5A);
  endfunction

  // Memory model: raises mem_ready for one cycle after mem_wait BUSY cycles.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = 32'hBAD0_BAD0;
      if (mem_req && mem_en) begin
        if (cnt == mem_wait) begin
          mem_ready = 1'b1;
          mem_rdata = mem_f(mem_addr);
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: grants and acks are checked against the scoreboard queues.
  initial begin
    bit prev_req = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (d_ack) n_d_ack++;
        if (if_ack || d_ack) begin
          check("ack_exclusive", {31'd0, if_ack & d_ack}, 32'd0);
          check("ack_sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("ack_port_d", {31'd0, d_ack}, {31'd0, e.port_d});
            check("ack_rdata", d_ack ? d_rdata : if_rdata, e.rdata);
            check("ack_err", {31'd0, err}, {31'd0, e.err});
          end
        end else begin
          check("err_outside_resp", {31'd0, err}, 32'd0);
        end
        if (mem_req && !prev_req) begin
          check("grant_sb_nonempty", {31'd0, grant_q.size() != 0}, 32'd1);
          if (grant_q.size() != 0) check("grant_addr", mem_addr, grant_q.pop_front());
        end
      end
      prev_req = mem_req;
    end
  end

  task automatic run_until(input int n, input int budget, output int cyc_out);
    int got = 0;
    int c = 0;
    while (got < n && c < budget) begin
      @(negedge clk);
      c++;
      if (mem_req) n_busy++;
      if (chk_store && mem_req) begin
        check("store_we", {31'd0, mem_we}, 32'd1);
        check("store_wdata", mem_wdata, 32'hDEAD_BEEF);
        n_store++;
      end
      if (if_ack) begin
        got++;
        if (!if_hold) if_req = 1'b0;
      end
      if (d_ack) begin
        got++;
        if (!d_hold) d_req = 1'b0;
      end
    end
    check("ack_budget", got, n);
    cyc_out = c;
  endtask

  initial begin
    int cyc;
    int acks_before;

    // Reset state
    #2;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mon_en = 1;
    repeat (2) @(negedge clk);

    // Single fetch, two wait states
    mem_wait = 2;
    grant_q.push_back(32'h0040_0000);
    exp_q.push_back('{port_d: 1'b0, rdata: 32'h2008_0005, err: 1'b0});
    if_addr = 32'h0040_0000;
    if_req = 1'b1;
    run_until(1, 20, cyc);
    check("fetch_latency", cyc, 32'd4);
    repeat (2) @(negedge clk);

    // Simultaneous requests: data first
    mem_wait = 1;
    grant_q.push_back(32'h1001_0000);
    grant_q.push_back(32'h0040_0000);
    exp_q.push_back('{port_d: 1'b1, rdata: mem_f(32'h1001_0000), err: 1'b0});
    exp_q.push_back('{port_d: 1'b0, rdata: 32'h2008_0005, err: 1'b0});
    d_we = 1'b0;
    d_addr = 32'h1001_0000;
    if_req = 1'b1;
    d_req = 1'b1;
    run_until(2, 40, cyc);
    repeat (2) @(negedge clk);

    // Starvation: both held, zero-wait memory
    mem_wait = 0;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        grant_q.push_back(32'h1001_0000);
        exp_q.push_back('{port_d: 1'b1, rdata: mem_f(32'h1001_0000), err: 1'b0});
      end
      grant_q.push_back(32'h0040_0000);
      exp_q.push_back('{port_d: 1'b0, rdata: 32'h2008_0005, err: 1'b0});
    end
    if_hold = 1;
    d_hold = 1;
    if_req = 1'b1;
    d_req = 1'b1;
    run_until(10, 100, cyc);
    if_req = 1'b0;
    d_req = 1'b0;
    if_hold = 0;
    d_hold = 0;
    repeat (2) @(negedge clk);

    // Store: d_rdata must keep the last load value
    mem_wait = 3;
    grant_q.push_back(32'h1001_0040);
    exp_q.push_back('{port_d: 1'b1, rdata: mem_f(32'h1001_0000), err: 1'b0});
    d_we = 1'b1;
    d_addr = 32'h1001_0040;
    d_wdata = 32'hDEAD_BEEF;
    n_store = 0;
    chk_store = 1;
    d_req = 1'b1;
    run_until(1, 20, cyc);
    chk_store = 0;
    check("store_busy_cycles", n_store, 32'd4);
    d_we = 1'b0;
    repeat (2) @(negedge clk);

    // Timeout: memory never answers
    mem_en = 0;
    grant_q.push_back(32'h0040_0100);
    exp_q.push_back('{port_d: 1'b0, rdata: 32'h2008_0005, err: 1'b1});
    if_addr = 32'h0040_0100;
    n_busy = 0;
    if_req = 1'b1;
    run_until(1, 400, cyc);
    check("timeout_busy_cycles", n_busy, 32'd255);
    @(negedge clk);
    check("timeout_back_idle", {31'd0, mem_req}, 32'd0);
    repeat (2) @(negedge clk);

    // Reset during a data access, then a fresh grant
    grant_q.push_back(32'h1001_0000);
    grant_q.push_back(32'h1001_0000);
    d_addr = 32'h1001_0000;
    d_req = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_reset_mem_req", {31'd0, mem_req}, 32'd1);
    acks_before = n_d_ack;
    reset = 1'b0;
    #1;
    check("reset_mem_req_now", {31'd0, mem_req}, 32'd0);
    repeat (3) @(negedge clk);
    check("reset_no_d_ack", n_d_ack, acks_before);
    check("reset_d_rdata", d_rdata, 32'd0);
    mem_en = 1;
    mem_wait = 0;
    exp_q.push_back('{port_d: 1'b1, rdata: mem_f(32'h1001_0000), err: 1'b0});
    reset = 1'b1;
    run_until(1, 20, cyc);
    repeat (3) @(negedge clk);

    check("sb_ack_drained", exp_q.size(), 32'd0);
    check("sb_grant_drained", grant_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL declare parameter STARVE_LIMIT, default 4, as the maximum number of consecutive data-port grants allowed while a fetch request waits.
REQ-002 The block SHALL declare parameter TIMEOUT, default 255, as the maximum number of BUSY cycles to wait for mem_ready before aborting.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port if_req, input, 1 bit: fetch-port request, held until if_ack.
REQ-006 The block SHALL have port if_addr, input, 32 bits: fetch address, stable while if_req is high.
REQ-007 The block SHALL have port if_rdata, output, 32 bits: fetch read data, valid while if_ack is high.
REQ-008 The block SHALL have port if_ack, output, 1 bit: one-cycle fetch completion pulse.
REQ-009 The block SHALL have port d_req, input, 1 bit: data-port request, held until d_ack.
REQ-010 The block SHALL have port d_we, input, 1 bit: data write enable (1 = store, 0 = load).
REQ-011 The block SHALL have port d_addr, input, 32 bits: data address.
REQ-012 The block SHALL have port d_wdata, input, 32 bits: store data.
REQ-013 The block SHALL have port d_rdata, output, 32 bits: load data, valid while d_ack is high.
REQ-014 The block SHALL have port d_ack, output, 1 bit: one-cycle data completion pulse.
REQ-015 The block SHALL have port mem_req, output, 1 bit: shared memory request.
REQ-016 The block SHALL have port mem_we, output, 1 bit: shared memory write enable.
REQ-017 The block SHALL have ports mem_addr and mem_wdata, outputs, 32 bits each: shared memory address and write data.
REQ-018 The block SHALL have port mem_rdata, input, 32 bits: memory read data, valid when mem_ready is high.
REQ-019 The block SHALL have port mem_ready, input, 1 bit: memory completion.
REQ-020 The block SHALL have port err, output, 1 bit: timeout flag, asserted together with the ack of an aborted access.

Function
REQ-021 The FSM SHALL have states IDLE, BUSY_I, BUSY_D, RESP_I and RESP_D; arbitration SHALL occur only in IDLE.
REQ-022 In IDLE with both requests high, the FSM SHALL go to BUSY_D, unless the starvation count equals STARVE_LIMIT, in which case it SHALL go to BUSY_I.
REQ-023 In IDLE with a single request high, the FSM SHALL go to that port's BUSY state; with no request it SHALL stay in IDLE.
REQ-024 The starvation count (3-bit, saturating) SHALL increment on each BUSY_D grant made while if_req is high, SHALL clear on any BUSY_I grant, and SHALL hold otherwise.
REQ-025 In BUSY_x, the outputs SHALL be mem_req=1 with mem_addr/mem_we/mem_wdata driven from the granted port's inputs; the fetch port SHALL always drive mem_we=0 and mem_wdata=0.
REQ-026 Outside BUSY, the outputs SHALL be mem_req=0, mem_we=0, mem_addr=0 and mem_wdata=0.
REQ-027 In BUSY_x with mem_ready=1, the FSM SHALL go to RESP_x and register mem_rdata into x_rdata, but only for reads; a store SHALL leave d_rdata unchanged.
REQ-028 In RESP_x, x_ack SHALL be 1 for exactly one cycle, after which the FSM SHALL return to IDLE.
REQ-029 Latency: a request seen in IDLE at cycle 0 with mem_ready at cycle 1+W SHALL produce ack at cycle 2+W.
REQ-030 A wait counter SHALL clear on entering BUSY and increment each BUSY cycle; if it reaches TIMEOUT without mem_ready, the FSM SHALL go to RESP_x with err=1 and x_rdata unchanged.
REQ-031 Outside RESP, err SHALL be 0.
REQ-032 Changes on if_req/d_req during BUSY or RESP SHALL be ignored; the granted access SHALL complete.
REQ-033 The requester SHALL deassert req in the cycle after ack, so the IDLE cycle after RESP never re-grants a finished access.
REQ-034 if_ack and d_ack SHALL never both be 1.
REQ-035 mem_req SHALL be 0 in IDLE and RESP, giving at least one idle memory cycle between accesses.

Reset
REQ-036 While reset=0, asynchronously: state=IDLE, if_ack=d_ack=err=0, mem_req=mem_we=0, mem_addr=mem_wdata=0, if_rdata=d_rdata=0, starvation and wait counters=0.
REQ-037 Reset asserted mid-access SHALL abandon the access with no ack; after release, held requests SHALL be re-arbitrated from IDLE.

Verification
REQ-038 Bench: if_req alone, if_addr=0x00400000, mem_ready 2 cycles after mem_req rises with mem_rdata=0x20080005 -> if_ack one cycle later, if_rdata=0x20080005, err=0.
REQ-039 Bench: if_req and d_req together (d_we=0, d_addr=0x10010000) -> data access serviced first, mem_addr=0x10010000, d_ack before if_ack.
REQ-040 Bench: d_req held continuously plus if_req, zero-wait memory -> 4 data grants, then a fetch grant, starvation count back to 0.
REQ-041 Bench: store d_we=1, d_wdata=0xDEADBEEF -> mem_we=1 and mem_wdata=0xDEADBEEF throughout BUSY_D; d_ack pulses; d_rdata unchanged.
REQ-042 Bench: mem_ready never asserted -> ack with err=1 after TIMEOUT (255) BUSY cycles, then IDLE.
REQ-043 Bench: reset=0 during BUSY_D -> mem_req=0 immediately, no d_ack; after release with d_req still high -> a fresh grant.
